// File: rtl/tsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tsu_pkg
// Description : Shared timestamp-unit definitions: timestamp-queue record
//               layout, fetch FSM state encoding and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package tsu_pkg;

    // Timestamp-queue record layout (bit offsets and widths)
    localparam int TS_REC_WIDTH  = 128;
    localparam int TS_SEC_LSB    = 80;
    localparam int TS_SEC_W      = 48;
    localparam int TS_NSEC_LSB   = 48;
    localparam int TS_NSEC_W     = 32;
    localparam int TS_MSG_LSB    = 44;
    localparam int TS_MSG_W      = 4;
    localparam int TS_RSV_LSB    = 16;
    localparam int TS_RSV_W      = 28;
    localparam int TS_SEQ_LSB    = 0;
    localparam int TS_SEQ_W      = 16;

    // Drop counter width
    localparam int TS_DROP_W     = 16;

    // Fetch FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_CAPT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    // Saturating increment for the drop counter (sticks at all-ones)
    function automatic logic [TS_DROP_W-1:0] sat_inc(input logic [TS_DROP_W-1:0] v);
        return (v == {TS_DROP_W{1'b1}}) ? v : v + {{(TS_DROP_W-1){1'b0}}, 1'b1};
    endfunction

endpackage : tsu_pkg
`default_nettype wire

// File: rtl/ptp_ts_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ptp_ts_fetch
// Description : Pops one PTP timestamp record at a time from the timestamp
//               queue, decodes it and presents it on a valid/ready output.
//               A record left unaccepted for TIMEOUT_CYCLES is discarded
//               and counted in a saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ptp_ts_fetch
    import tsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned REC_WIDTH      = 128
) (
    input  logic                 q_rd_clk,
    input  logic                 q_rst,
    input  logic [7:0]           q_rd_stat,
    input  logic [REC_WIDTH-1:0] q_rd_data,
    output logic                 q_rd_en,
    output logic                 ts_valid,
    input  logic                 ts_ready,
    output logic [47:0]          ts_sec,
    output logic [31:0]          ts_nsec,
    output logic [3:0]           ts_msgtype,
    output logic [15:0]          ts_seqid,
    output logic [15:0]          drop_cnt,
    output logic                 irq
);

    // Wait counter only needs to reach TIMEOUT_CYCLES-1
    localparam int unsigned WAIT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam bit  TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;

    logic [TS_SEC_W-1:0]  rec_sec;
    logic [TS_NSEC_W-1:0] rec_nsec;
    logic [TS_MSG_W-1:0]  rec_msgtype;
    logic [TS_SEQ_W-1:0]  rec_seqid;
    logic                 unused_rsv;

    // Record field extraction; the reserved field carries no information
    assign rec_sec     = q_rd_data[TS_SEC_LSB  +: TS_SEC_W];
    assign rec_nsec    = q_rd_data[TS_NSEC_LSB +: TS_NSEC_W];
    assign rec_msgtype = q_rd_data[TS_MSG_LSB  +: TS_MSG_W];
    assign rec_seqid   = q_rd_data[TS_SEQ_LSB  +: TS_SEQ_W];
    assign unused_rsv  = ^q_rd_data[TS_RSV_LSB +: TS_RSV_W];

    // Any record bits above the defined layout are ignored
    generate
        if (REC_WIDTH > TS_REC_WIDTH) begin : g_wide_rec
            logic unused_hi;
            assign unused_hi = ^q_rd_data[REC_WIDTH-1:TS_REC_WIDTH];
        end
    endgenerate

    // State register
    always_ff @(posedge q_rd_clk or posedge q_rst) begin
        if (q_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; handshake beats timeout when both land on one cycle
    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (q_rd_stat != 8'd0) begin
                    state_next = ST_POP;
                end
            end
            ST_POP: begin
                state_next = ST_CAPT;
            end
            ST_CAPT: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (ts_ready) begin
                    state_next = ST_IDLE;
                end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                    timeout    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered strobes: pop during POP, valid/irq during HOLD
    always_ff @(posedge q_rd_clk or posedge q_rst) begin
        if (q_rst) begin
            q_rd_en  <= 1'b0;
            ts_valid <= 1'b0;
            irq      <= 1'b0;
        end else begin
            q_rd_en  <= (state_next == ST_POP);
            ts_valid <= (state_next == ST_HOLD);
            irq      <= (state_next == ST_HOLD);
        end
    end

    // Capture decoded fields when the queue presents the popped record
    always_ff @(posedge q_rd_clk or posedge q_rst) begin
        if (q_rst) begin
            ts_sec     <= '0;
            ts_nsec    <= '0;
            ts_msgtype <= '0;
            ts_seqid   <= '0;
        end else if (state == ST_CAPT) begin
            ts_sec     <= rec_sec;
            ts_nsec    <= rec_nsec;
            ts_msgtype <= rec_msgtype;
            ts_seqid   <= rec_seqid;
        end
    end

    // Cycles spent in HOLD; zero on entry and everywhere outside HOLD
    always_ff @(posedge q_rd_clk or posedge q_rst) begin
        if (q_rst) begin
            wait_cnt <= '0;
        end else if ((state == ST_HOLD) && (state_next == ST_HOLD)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Count discarded records, saturating at all-ones
    always_ff @(posedge q_rd_clk or posedge q_rst) begin
        if (q_rst) begin
            drop_cnt <= '0;
        end else if (timeout) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

endmodule : ptp_ts_fetch
`default_nettype wire

// File: tb/tb_ptp_ts_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ptp_ts_fetch
// Description : Self-checking bench for ptp_ts_fetch. Two instances share
//               the stimulus: one with an 8-cycle timeout, one that never
//               discards. A timeline model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ptp_ts_fetch;

    localparam int TMO [2] = '{8, 0};

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic [7:0]   stat  = 8'd0;
    logic [127:0] data  = '0;
    logic         ready = 1'b0;

    logic         en    [2];
    logic         valid [2];
    logic [47:0]  sec   [2];
    logic [31:0]  nsec  [2];
    logic [3:0]   msg   [2];
    logic [15:0]  seq   [2];
    logic [15:0]  drop  [2];
    logic         irq   [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Timeline model state
    bit           busy      [2];
    int           pop_at    [2];
    int           hold_from [2];
    logic [127:0] rec       [2];
    logic [15:0]  mdrop     [2];
    int           cyc;

    int           vt [$];
    logic [15:0]  vs [$];

    ptp_ts_fetch #(.TIMEOUT_CYCLES(8), .REC_WIDTH(128)) dut_a (
        .q_rd_clk(clk), .q_rst(rst), .q_rd_stat(stat), .q_rd_data(data),
        .q_rd_en(en[0]), .ts_valid(valid[0]), .ts_ready(ready),
        .ts_sec(sec[0]), .ts_nsec(nsec[0]), .ts_msgtype(msg[0]), .ts_seqid(seq[0]),
        .drop_cnt(drop[0]), .irq(irq[0])
    );

    ptp_ts_fetch #(.TIMEOUT_CYCLES(0), .REC_WIDTH(128)) dut_b (
        .q_rd_clk(clk), .q_rst(rst), .q_rd_stat(stat), .q_rd_data(data),
        .q_rd_en(en[1]), .ts_valid(valid[1]), .ts_ready(ready),
        .ts_sec(sec[1]), .ts_nsec(nsec[1]), .ts_msgtype(msg[1]), .ts_seqid(seq[1]),
        .drop_cnt(drop[1]), .irq(irq[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Model: a pop decided at end of cycle c strobes at c+1, captures data
    // at the end of c+2 and presents it from c+3 until accepted or timed out.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                busy[i]      = 1'b0;
                pop_at[i]    = -100;
                hold_from[i] = -100;
                mdrop[i]     = 16'd0;
            end
            cyc = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!busy[i]) begin
                    if (stat != 8'd0) begin
                        busy[i]      = 1'b1;
                        pop_at[i]    = cyc + 1;
                        hold_from[i] = cyc + 3;
                    end
                end else begin
                    if (cyc == hold_from[i] - 1) rec[i] = data;
                    if (cyc >= hold_from[i]) begin
                        if (ready) begin
                            busy[i] = 1'b0;
                        end else if (TMO[i] != 0 && (cyc - hold_from[i] + 1) == TMO[i]) begin
                            busy[i] = 1'b0;
                            if (mdrop[i] != 16'hFFFF) mdrop[i] = mdrop[i] + 16'd1;
                        end
                    end
                end
            end
            cyc = cyc + 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic ev;
                logic ee;
                ee = busy[i] && (cyc == pop_at[i]);
                ev = busy[i] && (cyc >= hold_from[i]);
                chk("q_rd_en", i, 64'(en[i]), 64'(ee));
                chk("ts_valid", i, 64'(valid[i]), 64'(ev));
                chk("irq", i, 64'(irq[i]), 64'(ev));
                chk("drop_cnt", i, 64'(drop[i]), 64'(mdrop[i]));
                if (ev) begin
                    chk("ts_sec", i, 64'(sec[i]), 64'(rec[i][127:80]));
                    chk("ts_nsec", i, 64'(nsec[i]), 64'(rec[i][79:48]));
                    chk("ts_msgtype", i, 64'(msg[i]), 64'(rec[i][47:44]));
                    chk("ts_seqid", i, 64'(seq[i]), 64'(rec[i][15:0]));
                end
            end
        end
    end

    task automatic wait_valid(input int inst);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = valid[inst];
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_valid[%0d] got no ts_valid expected ts_valid within 30 cycles", inst);
        end
    endtask

    task automatic drain();
        stat  = 8'd0;
        ready = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int run_a, run_b, pops, n, rem, thr;
        bit da, db;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", i, 64'(valid[i]), 64'd0);
            chk("rst_en", i, 64'(en[i]), 64'd0);
            chk("rst_irq", i, 64'(irq[i]), 64'd0);
            chk("rst_drop", i, 64'(drop[i]), 64'd0);
            chk("rst_sec", i, 64'(sec[i]), 64'd0);
            chk("rst_seqid", i, 64'(seq[i]), 64'd0);
        end
        #2 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("first_en", 0, 64'(en[0]), 64'd0);

        // Single record
        data  = {48'h0000_0000_0005, 32'h1DCD_6500, 4'h0, 28'h0, 16'h0042};
        ready = 1'b1;
        stat  = 8'd1;
        @(negedge clk);
        chk("single_pop", 0, 64'(en[0]), 64'd1);
        stat = 8'd0;
        @(negedge clk);
        chk("single_capt_valid", 0, 64'(valid[0]), 64'd0);
        @(negedge clk);
        chk("single_valid", 0, 64'(valid[0]), 64'd1);
        chk("single_sec", 0, 64'(sec[0]), 64'd5);
        chk("single_nsec", 0, 64'(nsec[0]), 64'd500000000);
        chk("single_msg", 0, 64'(msg[0]), 64'd0);
        chk("single_seqid", 0, 64'(seq[0]), 64'h42);
        @(negedge clk);
        chk("single_done", 0, 64'(valid[0]), 64'd0);
        drain();

        // Backpressure: ready low 10 cycles then high
        data  = {48'h0000_0000_1234, 32'd777, 4'h3, 28'hABCDEF0, 16'h0077};
        ready = 1'b0;
        stat  = 8'd1;
        wait_valid(1);
        run_a = 0; run_b = 0; da = 1'b0; db = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k == 10) ready = 1'b1;
            if (!da) begin if (valid[0]) run_a++; else da = 1'b1; end
            if (!db) begin if (valid[1]) run_b++; else db = 1'b1; end
            @(negedge clk);
        end
        chk("bp_hold_len", 1, 64'(run_b), 64'd11);
        chk("bp_drop", 1, 64'(drop[1]), 64'd0);
        chk("to_hold_len", 0, 64'(run_a), 64'd8);
        chk("to_drop", 0, 64'(drop[0]), 64'd1);
        drain();

        // Handshake on exactly the timeout cycle
        ready = 1'b0;
        stat  = 8'd1;
        wait_valid(0);
        stat = 8'd0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) ready = 1'b1;
            @(negedge clk);
        end
        chk("edge_drop", 0, 64'(drop[0]), 64'd1);
        drain();

        // Plain timeout
        ready = 1'b0;
        stat  = 8'd1;
        wait_valid(0);
        repeat (8) @(negedge clk);
        chk("to2_valid", 0, 64'(valid[0]), 64'd0);
        chk("to2_drop", 0, 64'(drop[0]), 64'd2);
        drain();

        // Stream of three records
        ready = 1'b1;
        stat  = 8'd3;
        rem   = 3;
        n     = 0;
        pops  = 0;
        @(negedge clk);
        for (int k = 0; k < 24; k++) begin
            if (en[1]) begin
                n++;
                pops++;
                data = {48'(n * 10), 32'(n), 4'(n), 28'h0, 16'(n)};
                rem  = rem - 1;
                stat = 8'(rem);
            end
            if (valid[1]) begin
                vt.push_back(k);
                vs.push_back(seq[1]);
            end
            @(negedge clk);
        end
        chk("stream_pops", 1, 64'(pops), 64'd3);
        chk("stream_xfers", 1, 64'(vt.size()), 64'd3);
        if (vt.size() == 3) begin
            chk("stream_seq0", 1, 64'(vs[0]), 64'd1);
            chk("stream_seq1", 1, 64'(vs[1]), 64'd2);
            chk("stream_seq2", 1, 64'(vs[2]), 64'd3);
            chk("stream_gap0", 1, 64'(vt[1] - vt[0]), 64'd4);
            chk("stream_gap1", 1, 64'(vt[2] - vt[1]), 64'd4);
        end
        drain();

        // Asynchronous reset while holding a record
        data  = {48'hABCD_0000_0001, 32'h1234_5678, 4'h9, 28'h0, 16'hBEEF};
        ready = 1'b0;
        stat  = 8'd1;
        wait_valid(1);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("ar_valid", i, 64'(valid[i]), 64'd0);
            chk("ar_irq", i, 64'(irq[i]), 64'd0);
            chk("ar_en", i, 64'(en[i]), 64'd0);
            chk("ar_sec", i, 64'(sec[i]), 64'd0);
            chk("ar_nsec", i, 64'(nsec[i]), 64'd0);
            chk("ar_msg", i, 64'(msg[i]), 64'd0);
            chk("ar_seqid", i, 64'(seq[i]), 64'd0);
            chk("ar_drop", i, 64'(drop[i]), 64'd0);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("ar_first_en", 0, 64'(en[0]), 64'd0);
        @(negedge clk);
        drain();

        // Drop counter saturation
        #2 force dut_a.drop_cnt = 16'hFFFE;
        mdrop[0] = 16'hFFFE;
        @(negedge clk);
        #2 release dut_a.drop_cnt;
        @(negedge clk);
        ready = 1'b0;
        stat  = 8'd1;
        repeat (40) @(negedge clk);
        chk("sat_drop", 0, 64'(drop[0]), 64'hFFFF);
        drain();

        // Randomised traffic
        thr = 5;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) thr = int'($urandom_range(0, 10));
            stat  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            ready = (int'($urandom_range(0, 9)) < thr);
            @(negedge clk);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ptp_ts_fetch
`default_nettype wire
